// File: rtl/cpu_stk.sv
`default_nettype none
// ============================================================================
// Module  : cpu_stk
// Purpose : Parametrised accumulator CPU with a data-memory handshake, a
//           hardware call/return stack, and sticky HALT and FAULT states.
// Rev     : 1.0
// ============================================================================
module cpu_stk #(
  parameter int DW = 8,
  parameter int AW = 8,
  parameter int PW = 8,
  parameter int SD = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   inst,
  output logic [PW-1:0] pc,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wdata,
  input  logic [DW-1:0] rdata,
  output logic          mem_req,
  output logic          mem_we,
  input  logic          mem_ack,
  output logic          halted,
  output logic          fault,
  output logic [DW-1:0] z
);

  localparam int SPW = $clog2(SD + 1);
  localparam int IW  = (SD > 1) ? $clog2(SD) : 1;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_MEM   = 2'd1,
    S_HALT  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t         r_state;
  logic [SPW-1:0] r_sp;
  logic [PW-1:0]  r_stack [SD];
  logic           r_wr_phase;
  logic [DW-1:0]  r_rdata;

  logic          w_is_imm, w_is_ctl, w_is_alu;
  logic          w_rd_op, w_wr_op, w_halt_now;
  logic          w_push_ok, w_pop_ok, w_alu_done;
  logic          w_eq, w_lt, w_gt, w_jump;
  logic [1:0]    w_op;
  logic [PW-1:0] w_pc_inc;
  logic [DW-1:0] w_x, w_x0, w_y0, w_x1, w_y1, w_s, w_rev, w_r;

  assign w_is_imm   = (inst[15:14] == 2'b00);
  assign w_is_ctl   = (inst[15:14] == 2'b01);
  assign w_is_alu   = inst[15];
  assign w_op       = inst[13:12];
  assign w_rd_op    = w_is_alu && (inst[9:8] == 2'b11);
  assign w_wr_op    = w_is_alu && inst[7];
  assign w_pc_inc   = pc + PW'(1);
  assign w_halt_now = (&pc) || (inst == 16'h0000) || (w_is_ctl && (w_op == 2'b11));

  assign w_push_ok = (r_state == S_RUN) && !w_halt_now && w_is_ctl &&
                     (w_op == 2'b00) && (r_sp != SPW'(SD));
  assign w_pop_ok  = (r_sp != '0);

  // A combined read+write instruction completes only after its second handshake
  assign w_alu_done = ((r_state == S_RUN) && !w_halt_now && w_is_alu && !w_rd_op && !w_wr_op) ||
                      ((r_state == S_MEM) && mem_ack && !(w_rd_op && w_wr_op && !r_wr_phase));

  always_comb begin
    w_x = z;
    case (inst[9:8])
      2'b00:   w_x = z;
      2'b01:   w_x = DW'(addr);
      2'b10:   w_x = DW'(pc);
      default: w_x = r_wr_phase ? r_rdata : rdata;
    endcase
    w_x0 = inst[1] ? '0 : w_x;
    w_y0 = inst[0] ? '0 : wdata;
    w_x1 = inst[3] ? ~w_x0 : w_x0;
    w_y1 = inst[2] ? ~w_y0 : w_y0;
    w_s  = inst[4] ? (w_x1 + w_y1) : (w_x1 & w_y1);
    w_rev = '0;
    for (int i = 0; i < DW; i++) begin
      w_rev[i] = w_s[DW-1-i];
    end
    w_r = inst[5] ? w_rev : w_s;
    if (inst[6]) begin
      w_r = ~w_r;
    end
  end

  assign w_eq   = (w_r == '0);
  assign w_lt   = w_r[DW-1];
  assign w_gt   = !w_eq && !w_lt;
  assign w_jump = (inst[12] && w_gt) || (inst[11] && w_lt) || (inst[10] && w_eq);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_RUN;
      pc         <= '0;
      addr       <= '0;
      wdata      <= '0;
      z          <= '0;
      r_sp       <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      r_wr_phase <= 1'b0;
      r_rdata    <= '0;
      halted     <= 1'b0;
      fault      <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_halt_now) begin
            r_state <= S_HALT;
            halted  <= 1'b1;
          end else if (w_is_imm) begin
            if (inst[13]) addr  <= AW'(inst[11:0]);
            if (inst[12]) wdata <= DW'(inst[11:0]);
            pc <= w_pc_inc;
          end else if (w_is_ctl) begin
            case (w_op)
              2'b00: begin
                if (w_push_ok) begin
                  r_sp <= r_sp + SPW'(1);
                  pc   <= PW'(addr);
                end else begin
                  r_state <= S_FAULT;
                  fault   <= 1'b1;
                end
              end
              2'b01: begin
                if (w_pop_ok) begin
                  r_sp <= r_sp - SPW'(1);
                  pc   <= r_stack[IW'(r_sp - SPW'(1))];
                end else begin
                  r_state <= S_FAULT;
                  fault   <= 1'b1;
                end
              end
              default: pc <= w_pc_inc;
            endcase
          end else if (w_rd_op || w_wr_op) begin
            // Read goes first when an instruction both reads and writes
            r_state    <= S_MEM;
            mem_req    <= 1'b1;
            mem_we     <= !w_rd_op;
            r_wr_phase <= 1'b0;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            if (w_rd_op && w_wr_op && !r_wr_phase) begin
              r_rdata    <= rdata;
              r_wr_phase <= 1'b1;
              mem_we     <= 1'b1;
            end else begin
              r_state    <= S_RUN;
              mem_req    <= 1'b0;
              mem_we     <= 1'b0;
              r_wr_phase <= 1'b0;
            end
          end
        end
        default: ;
      endcase

      if (w_alu_done) begin
        z  <= w_r;
        pc <= w_jump ? PW'(addr) : w_pc_inc;
        if (inst[14]) addr  <= AW'(w_r);
        if (inst[13]) wdata <= w_r;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_stack[IW'(r_sp)] <= w_pc_inc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_stk.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu_stk
// Purpose : Self-checking bench for cpu_stk (DW=AW=PW=8, SD=4).
// Rev     : 1.0
// ============================================================================
module tb_cpu_stk;

  typedef struct {
    logic [7:0]  zv;
    logic [7:0]  w;
    logic [15:0] op;
    logic [7:0]  ez;
    logic [7:0]  ea;
    logic [7:0]  ew;
    logic [7:0]  epc;
  } vec_t;

  localparam int NV = 15;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic [15:0] inst = 16'h6000;
  logic [7:0]  pc, addr, wdata, rdata, z;
  logic        mem_req, mem_we, mem_ack, halted, fault;

  logic [7:0]  ram [256];
  int          ack_lat = 0;
  int          req_cnt = 0;
  int          n_cmp   = 0;
  int          n_bad   = 0;

  vec_t        vt [NV];
  vec_t        exp_q [$];
  vec_t        e;
  logic [7:0]  rq [$];
  logic [7:0]  ep, tgt;
  int          cnt;
  logic        we_seen, addr_bad;

  cpu_stk #(.DW(8), .AW(8), .PW(8), .SD(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .inst    (inst),
    .pc      (pc),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .mem_req (mem_req),
    .mem_we  (mem_we),
    .mem_ack (mem_ack),
    .halted  (halted),
    .fault   (fault),
    .z       (z)
  );

  always #5 clk = ~clk;

  // Data RAM with a programmable acknowledge latency (0 = same-cycle ack)
  assign rdata   = ram[addr];
  assign mem_ack = mem_req && (req_cnt >= ack_lat);

  always @(posedge clk) begin
    if (mem_req && mem_ack) begin
      if (mem_we) ram[addr] = wdata;
      req_cnt <= 0;
    end else if (mem_req) begin
      req_cnt <= req_cnt + 1;
    end else begin
      req_cnt <= 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    inst    = 16'h6000;
    ack_lat = 0;
    rst     = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic exec(input logic [15:0] i);
    inst = i;
    @(negedge clk);
  endtask

  // Runs a memory instruction until pc leaves start_pc, with a cycle bound
  task automatic run_mem(input logic [15:0] i, input logic [7:0] start_pc, input logic [7:0] exp_addr);
    inst     = i;
    cnt      = 0;
    we_seen  = 1'b0;
    addr_bad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_req) cnt++;
      if (mem_req && mem_we) we_seen = 1'b1;
      if (mem_req && addr != exp_addr) addr_bad = 1'b1;
      if (pc != start_pc) break;
    end
  endtask

  task automatic do_calls();
    ep = 8'h00;
    rq.delete();
    for (int k = 0; k < 4; k++) begin
      tgt = 8'((k + 1) * 16);
      exec(16'h2000 | 16'(tgt));
      ep = ep + 8'd1;
      rq.push_back(ep + 8'd1);
      exec(16'h4000);
      ep = tgt;
      chk($sformatf("call%0d_pc", k), 32'(pc), 32'(ep));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 256; a++) ram[a] = 8'(a) ^ 8'h5A;

    //         zv     w      op        ez     ea     ew     epc
    vt[0]  = '{8'h00, 8'h05, 16'hA012, 8'h05, 8'h20, 8'h05, 8'h05};
    vt[1]  = '{8'h05, 8'h05, 16'h8014, 8'hFF, 8'h20, 8'h05, 8'h05};
    vt[2]  = '{8'h09, 8'h09, 16'h8413, 8'h00, 8'h20, 8'h09, 8'h20};
    vt[3]  = '{8'h00, 8'h01, 16'h8412, 8'h01, 8'h20, 8'h01, 8'h05};
    vt[4]  = '{8'h00, 8'h80, 16'h8812, 8'h80, 8'h20, 8'h80, 8'h20};
    vt[5]  = '{8'h00, 8'h7F, 16'h9012, 8'h7F, 8'h20, 8'h7F, 8'h20};
    vt[6]  = '{8'h00, 8'h00, 16'h9013, 8'h00, 8'h20, 8'h00, 8'h05};
    vt[7]  = '{8'hF0, 8'h3C, 16'h8000, 8'h30, 8'h20, 8'h3C, 8'h05};
    vt[8]  = '{8'h01, 8'h55, 16'h8031, 8'h80, 8'h20, 8'h55, 8'h05};
    vt[9]  = '{8'h0F, 8'h00, 16'h8051, 8'hF0, 8'h20, 8'h00, 8'h05};
    vt[10] = '{8'h0F, 8'h01, 16'h8018, 8'hF1, 8'h20, 8'h01, 8'h05};
    vt[11] = '{8'h00, 8'h03, 16'hC110, 8'h23, 8'h23, 8'h03, 8'h05};
    vt[12] = '{8'h00, 8'h10, 16'h8210, 8'h14, 8'h20, 8'h10, 8'h05};
    vt[13] = '{8'hFF, 8'h02, 16'h8010, 8'h01, 8'h20, 8'h02, 8'h05};
    vt[14] = '{8'h00, 8'h90, 16'hE812, 8'h90, 8'h90, 8'h90, 8'h20};

    do_reset();
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_addr", 32'(addr), 32'h0);
    chk("rst_wdata", 32'(wdata), 32'h0);
    chk("rst_z", 32'(z), 32'h0);
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);

    // Immediate truncation to 8 bits for both targets
    exec(16'h3ABC);
    chk("imm_addr", 32'(addr), 32'hBC);
    chk("imm_wdata", 32'(wdata), 32'hBC);
    chk("imm_pc", 32'(pc), 32'h01);

    // ALU vector table: addr=0x20, z=zv, wdata=w, then op executes at pc=4
    for (int i = 0; i < NV; i++) begin
      do_reset();
      exec(16'h2020);
      exec(16'h1000 | 16'(vt[i].zv));
      exec(16'h8012);
      exec(16'h1000 | 16'(vt[i].w));
      exp_q.push_back(vt[i]);
      exec(vt[i].op);
      e = exp_q.pop_front();
      chk($sformatf("v%0d_z", i), 32'(z), 32'(e.ez));
      chk($sformatf("v%0d_addr", i), 32'(addr), 32'(e.ea));
      chk($sformatf("v%0d_wdata", i), 32'(wdata), 32'(e.ew));
      chk($sformatf("v%0d_pc", i), 32'(pc), 32'(e.epc));
    end

    // Read with three cycles of request before ack
    do_reset();
    ram[8'h10] = 8'h2A;
    exec(16'h2010);
    ack_lat = 2;
    run_mem(16'h8311, 8'h01, 8'h10);
    chk("rd_req_cycles", 32'(cnt), 32'd3);
    chk("rd_we", 32'(we_seen), 32'h0);
    chk("rd_addr_stable", 32'(addr_bad), 32'h0);
    chk("rd_z", 32'(z), 32'h2A);
    chk("rd_pc", 32'(pc), 32'h02);
    chk("rd_req_drop", 32'(mem_req), 32'h0);
    exec(16'h6000);
    chk("rd_pc_next", 32'(pc), 32'h03);

    // Write with same-cycle ack
    do_reset();
    exec(16'h2040);
    exec(16'h1077);
    ack_lat = 0;
    run_mem(16'h8080, 8'h02, 8'h40);
    chk("wr_req_cycles", 32'(cnt), 32'd1);
    chk("wr_we", 32'(we_seen), 32'h1);
    chk("wr_ram", 32'(ram[8'h40]), 32'h77);
    chk("wr_pc", 32'(pc), 32'h03);

    // Read then write to the same address in one instruction
    do_reset();
    ram[8'h50] = 8'h11;
    exec(16'h2050);
    exec(16'h1022);
    run_mem(16'h8391, 8'h02, 8'h50);
    chk("rw_req_cycles", 32'(cnt), 32'd2);
    chk("rw_ram", 32'(ram[8'h50]), 32'h22);
    chk("rw_z", 32'(z), 32'h11);
    chk("rw_pc", 32'(pc), 32'h03);

    // Four nested calls and four returns
    do_reset();
    do_calls();
    for (int k = 0; k < 4; k++) begin
      exec(16'h5000);
      ep = rq.pop_back();
      chk($sformatf("ret%0d_pc", k), 32'(pc), 32'(ep));
    end
    chk("ret_fault", 32'(fault), 32'h0);

    // Fifth nested call overflows
    do_reset();
    do_calls();
    exec(16'h2050);
    exec(16'h4000);
    chk("ovf_fault", 32'(fault), 32'h1);
    chk("ovf_pc", 32'(pc), 32'h41);
    repeat (3) exec(16'h6000);
    chk("ovf_pc_frozen", 32'(pc), 32'h41);
    chk("ovf_fault_sticky", 32'(fault), 32'h1);

    // Return with an empty stack
    do_reset();
    exec(16'h5000);
    chk("unf_fault", 32'(fault), 32'h1);
    chk("unf_pc", 32'(pc), 32'h00);

    // HALT opcode freezes the core
    do_reset();
    exec(16'h1005);
    exec(16'h7000);
    chk("halt_flag", 32'(halted), 32'h1);
    chk("halt_pc", 32'(pc), 32'h01);
    for (int c = 0; c < 10; c++) exec(16'h2033);
    chk("halt_pc_frozen", 32'(pc), 32'h01);
    chk("halt_addr_frozen", 32'(addr), 32'h00);
    chk("halt_wdata", 32'(wdata), 32'h05);
    do_reset();
    chk("halt_exit_rst", 32'(halted), 32'h0);

    // All-zero instruction also halts
    exec(16'h0000);
    chk("halt0_flag", 32'(halted), 32'h1);
    exec(16'h2033);
    chk("halt0_addr", 32'(addr), 32'h00);

    // Reset asserted while waiting for ack
    do_reset();
    exec(16'h2010);
    exec(16'h1033);
    ack_lat = 1000;
    inst = 16'h8311;
    @(negedge clk);
    @(negedge clk);
    chk("mrst_req_before", 32'(mem_req), 32'h1);
    #2 rst = 1'b1;
    #1 chk("mrst_req_async", 32'(mem_req), 32'h0);
    @(negedge clk);
    inst    = 16'h6000;
    ack_lat = 0;
    rst     = 1'b0;
    chk("mrst_pc", 32'(pc), 32'h0);
    chk("mrst_addr", 32'(addr), 32'h0);
    chk("mrst_wdata", 32'(wdata), 32'h0);
    chk("mrst_z", 32'(z), 32'h0);
    chk("mrst_we", 32'(mem_we), 32'h0);
    exec(16'h6000);
    chk("mrst_run_pc", 32'(pc), 32'h01);
    chk("mrst_run_req", 32'(mem_req), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
